moore_101_nonoverlap: RTL and testbench

MOORE_101_NONOVERLAP -- requirements
Module: moore_101_nonoverlap

---
 rtl/moore_101_nonoverlap.sv | 98 +++++++++
 tb/tb_moore_101_nonoverlap.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/moore_101_nonoverlap.sv
// -----------------------------------------------------------------------------
// moore_101_nonoverlap
//
// Purpose:
//   Serial "101" pattern detector built as a four-state Moore machine.
//   Detection is non-overlapping: once a "101" completes, none of its bits is
//   reused, so the next detection needs three fresh bits.
//
// Ports:
//   clk   in  1  rising-edge clock, single clock domain
//   rst_n in  1  synchronous reset, ACTIVE-HIGH despite the name
//                (state clears when rst_n=1 at a rising clk edge)
//   din   in  1  serial data bit, sampled on every rising clk edge
//   dout  out 1  detect flag, high for the single cycle spent in S_DET
// -----------------------------------------------------------------------------
module moore_101_nonoverlap (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,  // no useful prefix
        S_1    = 2'b01,  // "1" seen
        S_10   = 2'b10,  // "10" seen
        S_DET  = 2'b11   // "101" complete
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   dout_r;

    // Output decode of a state: only S_DET raises the detect flag.
    function automatic logic det_decode(input state_t s);
        logic hit;
        if (s == S_DET) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    // State and output registers; dout_r always mirrors the decode of the
    // state it is loaded alongside, so dout never sees din combinationally.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r <= S_IDLE;
            dout_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            dout_r  <= det_decode(state_nxt_s);
        end
    end

    // Next-state logic. Leaving S_DET on a '1' goes to S_1 because that '1'
    // is a new bit; the final '1' of the detected pattern is not carried over.
    always_comb begin
        state_nxt_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (din) begin
                    state_nxt_s = S_1;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_1: begin
                if (din) begin
                    state_nxt_s = S_1;
                end else begin
                    state_nxt_s = S_10;
                end
            end
            S_10: begin
                if (din) begin
                    state_nxt_s = S_DET;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_DET: begin
                if (din) begin
                    state_nxt_s = S_1;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    assign dout = dout_r;

endmodule

// File: tb/tb_moore_101_nonoverlap.sv
// -----------------------------------------------------------------------------
// tb_moore_101_nonoverlap
//
// Self-checking bench for moore_101_nonoverlap. The reference model keeps the
// bits received since the last reset or detection in a queue; a detection is
// reported when that queue holds at least three bits ending in 1,0,1, after
// which the queue is emptied (non-overlap). Directed streams are followed by
// a randomized stream with occasional resets.
// -----------------------------------------------------------------------------
module tb_moore_101_nonoverlap;

    logic clk;
    logic rst_n;
    logic din;
    logic dout;

    int   checks;
    int   errors;
    int   pulses;
    bit   hist[$];
    logic exp_dout;

    moore_101_nonoverlap dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .dout  (dout)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: expected dout after a clock edge with inputs b / r.
    function automatic logic model_step(input logic b, input logic r);
        logic hit;
        hit = 1'b0;
        if (r) begin
            hist.delete();
        end else begin
            hist.push_back(b);
            if (hist.size() >= 3) begin
                if (hist[hist.size()-3] == 1'b1 &&
                    hist[hist.size()-2] == 1'b0 &&
                    hist[hist.size()-1] == 1'b1) begin
                    hit = 1'b1;
                    hist.delete();
                end
            end
        end
        return hit;
    endfunction

    // One clock: drive on the falling edge, check 1 unit after the rising edge.
    task automatic step(input logic b, input logic r, input string tag);
        @(negedge clk);
        din   = b;
        rst_n = r;
        @(posedge clk);
        #1;
        exp_dout = model_step(b, r);
        checks++;
        assert (dout === exp_dout) else begin
            errors++;
            $error("FAIL %s: observed dout=%0b expected=%0b", tag, dout, exp_dout);
        end
        if (dout === 1'b1) begin
            pulses++;
        end
    endtask

    // Reset for one edge, then clear the pulse counter for the next stream.
    task automatic do_reset(input string tag);
        step(1'($urandom_range(1, 0)), 1'b1, tag);
        pulses = 0;
    endtask

    // Feed n bits of 'bits' MSB first and compare the number of pulses seen.
    task automatic run_seq(input logic [15:0] bits, input int n,
                           input int exp_pulses, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i], 1'b0, tag);
        end
        checks++;
        assert (pulses === exp_pulses) else begin
            errors++;
            $error("FAIL %s_pulses: observed=%0d expected=%0d", tag, pulses, exp_pulses);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pulses = 0;
        din    = 1'b0;
        rst_n  = 1'b1;

        // Reset held for several edges with arbitrary din: dout must read 0.
        for (int i = 0; i < 4; i++) begin
            step(1'($urandom_range(1, 0)), 1'b1, "reset_hold");
        end

        // Two pulses, after bits 3 and 6.
        do_reset("rst");
        run_seq(16'b101101001, 9, 2, "seq_101101001");

        // Non-overlap: only one pulse.
        do_reset("rst");
        run_seq(16'b10101, 5, 1, "seq_10101");

        // Partial "10", then "0", then a full "101".
        do_reset("rst");
        run_seq(16'b100101, 6, 1, "seq_10_0_101");

        // Run of ones then "01".
        do_reset("rst");
        run_seq(16'b11101, 5, 1, "seq_11101");

        // "1100" returns to idle; a lone trailing '1' must not detect.
        do_reset("rst");
        run_seq(16'b11001, 5, 0, "seq_11001");

        // "1101" detects.
        do_reset("rst");
        run_seq(16'b1101, 4, 1, "seq_1101");

        // Reset mid-pattern discards the "10" prefix.
        do_reset("rst");
        step(1'b1, 1'b0, "mid_rst");
        step(1'b0, 1'b0, "mid_rst");
        step(1'b1, 1'b1, "mid_rst_edge");
        step(1'b1, 1'b0, "mid_rst_after");
        step(1'b0, 1'b0, "mid_rst_after");
        checks++;
        assert (pulses === 0) else begin
            errors++;
            $error("FAIL mid_rst_pulses: observed=%0d expected=%0d", pulses, 0);
        end

        // Reset on the edge after reaching S_DET forces dout low.
        do_reset("rst");
        step(1'b1, 1'b0, "det_rst");
        step(1'b0, 1'b0, "det_rst");
        step(1'b1, 1'b0, "det_rst_pulse");
        step(1'b1, 1'b1, "det_rst_edge");
        step(1'b0, 1'b0, "det_rst_after");
        checks++;
        assert (pulses === 1) else begin
            errors++;
            $error("FAIL det_rst_pulses: observed=%0d expected=%0d", pulses, 1);
        end

        // Randomized stream with sparse resets against the queue model.
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(1, 0)), ($urandom_range(19, 0) == 0), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
